// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, coordinate type and line/frame total helper.
// Default timing is 640x480@60.
package vga_timing_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam bit SYNC_POL_DEF  = 1'b0;

  localparam int COORD_MAX_TOTAL = 1024;

  typedef logic [9:0] vga_coord_t;

  function automatic int vga_total(input int disp, input int front, input int sync, input int back);
    return disp + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-(MAX+1) up-counter; wrap is high while inc is set and the count is at MAX,
// i.e. during the cycle whose clock edge takes the count from MAX back to 0.
module vga_wrap_counter #(
  parameter int MAX = 799,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_C = MAX[W-1:0];
  localparam logic [W-1:0] ONE_C = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q, count_d;

  // wrap is combinational so a chained counter can advance on the same edge
  assign wrap = inc && (count_q == MAX_C);

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = (count_q == MAX_C) ? '0 : count_q + ONE_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel position, registered sync/display-enable decodes and line/frame strobes.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit SYNC_POL  = SYNC_POL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output vga_coord_t hpos,
  output vga_coord_t vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame
);

  localparam int H_TOTAL = vga_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = vga_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > COORD_MAX_TOTAL) begin : g_h_total_err
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > COORD_MAX_TOTAL) begin : g_v_total_err
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end

  localparam vga_coord_t H_DISP_C  = vga_coord_t'(H_DISPLAY);
  localparam vga_coord_t H_SBEG_C  = vga_coord_t'(H_DISPLAY + H_FRONT);
  localparam vga_coord_t H_SEND_C  = vga_coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam vga_coord_t V_DISP_C  = vga_coord_t'(V_DISPLAY);
  localparam vga_coord_t V_SBEG_C  = vga_coord_t'(V_DISPLAY + V_FRONT);
  localparam vga_coord_t V_SEND_C  = vga_coord_t'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam vga_coord_t ONE_C     = vga_coord_t'(1);

  vga_coord_t h_cnt, v_cnt, h_nxt, v_nxt;
  logic       h_wrap, v_wrap, v_inc;

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic display_on_q, display_on_d;
  logic line_start_q, frame_start_q;

  assign v_inc = ena & h_wrap;

  vga_wrap_counter #(.MAX(H_TOTAL - 1), .W(10)) u_h (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ena),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  vga_wrap_counter #(.MAX(V_TOTAL - 1), .W(10)) u_v (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (v_inc),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  // Decode the post-edge position so sync/enable line up with hpos/vpos
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (ena) begin
      h_nxt = h_wrap ? '0 : h_cnt + ONE_C;
    end
    if (v_inc) begin
      v_nxt = v_wrap ? '0 : v_cnt + ONE_C;
    end
    hsync_d      = ((h_nxt >= H_SBEG_C) && (h_nxt < H_SEND_C)) ? SYNC_POL : ~SYNC_POL;
    vsync_d      = ((v_nxt >= V_SBEG_C) && (v_nxt < V_SEND_C)) ? SYNC_POL : ~SYNC_POL;
    display_on_d = (h_nxt < H_DISP_C) && (v_nxt < V_DISP_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap & v_wrap;
      if (ena) begin
        hsync_q      <= hsync_d;
        vsync_q      <= vsync_d;
        display_on_q <= display_on_d;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (h_wrap & v_wrap) begin
      frame_q <= frame_q + 8'd1;
    end
  end

  assign frame = frame_q;
`else
  assign frame = '0;
`endif

  assign hpos        = h_cnt;
  assign vpos        = v_cnt;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance plus a small-timing instance
// (so whole frames fit in a short run), both checked against a pixel-index model.
module tb_vga_timing_gen;

  localparam int S_HD = 20, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VD = 10, S_VF = 2, S_VS = 2, S_VB = 3;

  int HD[2] = '{640, S_HD};
  int HF[2] = '{16,  S_HF};
  int HS[2] = '{96,  S_HS};
  int HT[2] = '{800, S_HD + S_HF + S_HS + S_HB};
  int VD[2] = '{480, S_VD};
  int VF[2] = '{10,  S_VF};
  int VS[2] = '{2,   S_VS};
  int VT[2] = '{525, S_VD + S_VF + S_VS + S_VB};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena_b = 1'b0, ena_s = 1'b0;

  logic [9:0] hpos_b, vpos_b, hpos_s, vpos_s;
  logic hsync_b, vsync_b, disp_b, ls_b, fs_b;
  logic hsync_s, vsync_s, disp_s, ls_s, fs_s;
  logic [7:0] frame_b, frame_s;

  int n_chk = 0;
  int n_pass = 0;

  int m_hp[2], m_vp[2], m_fr[2];
  bit m_blk[2], m_ls[2], m_fs[2];

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena_b),
    .hpos(hpos_b), .vpos(vpos_b), .hsync(hsync_b), .vsync(vsync_b),
    .display_on(disp_b), .line_start(ls_b), .frame_start(fs_b), .frame(frame_b)
  );

  vga_timing_gen #(
    .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .ena(ena_s),
    .hpos(hpos_s), .vpos(vpos_s), .hsync(hsync_s), .vsync(vsync_s),
    .display_on(disp_s), .line_start(ls_s), .frame_start(fs_s), .frame(frame_s)
  );

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_hp[i] = 0; m_vp[i] = 0; m_fr[i] = 0;
      m_blk[i] = 1'b1; m_ls[i] = 1'b0; m_fs[i] = 1'b0;
    end
  endfunction

  // Raster as a linear pixel index within the frame
  task automatic tick();
    bit en;
    int pos;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      en = (i == 0) ? ena_b : ena_s;
      if (en) begin
        pos = (m_vp[i] * HT[i] + m_hp[i] + 1) % (HT[i] * VT[i]);
        m_hp[i] = pos % HT[i];
        m_vp[i] = pos / HT[i];
        m_ls[i] = (m_hp[i] == 0);
        m_fs[i] = (pos == 0);
        if (pos == 0) m_fr[i] = m_fr[i] + 1;
        m_blk[i] = 1'b0;
      end else begin
        m_ls[i] = 1'b0;
        m_fs[i] = 1'b0;
      end
    end
    #1;
  endtask

  function automatic logic [32:0] exp_vec(int i);
    logic hs, vs, de;
    logic [7:0] f;
    hs = (m_hp[i] >= HD[i] + HF[i] && m_hp[i] < HD[i] + HF[i] + HS[i]) ? 1'b0 : 1'b1;
    vs = (m_vp[i] >= VD[i] + VF[i] && m_vp[i] < VD[i] + VF[i] + VS[i]) ? 1'b0 : 1'b1;
    de = !m_blk[i] && (m_hp[i] < HD[i]) && (m_vp[i] < VD[i]);
`ifdef VGA_TIMING_FRAME_CNT_EN
    f = 8'(m_fr[i] % 256);
`else
    f = 8'd0;
`endif
    return {10'(m_hp[i]), 10'(m_vp[i]), hs, vs, de, m_ls[i], m_fs[i], f};
  endfunction

  function automatic logic [32:0] act_vec(int i);
    if (i == 0) return {hpos_b, vpos_b, hsync_b, vsync_b, disp_b, ls_b, fs_b, frame_b};
    return {hpos_s, vpos_s, hsync_s, vsync_s, disp_s, ls_s, fs_s, frame_s};
  endfunction

  task automatic test_reset();
    logic [32:0] rst_vec;
    rst_vec = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    rst_n = 1'b0; ena_b = 1'b0; ena_s = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (hpos_b !== 10'd0 || vpos_b !== 10'd0) $display("FAIL reset_pos got (%0d,%0d) want (0,0)", hpos_b, vpos_b);
    else n_pass++;
    n_chk++;
    if ({hsync_b, vsync_b, disp_b} !== 3'b110) $display("FAIL reset_sync got hs=%b vs=%b de=%b want 1 1 0", hsync_b, vsync_b, disp_b);
    else n_pass++;
    n_chk++;
    if ({ls_b, fs_b, frame_b} !== 10'd0) $display("FAIL reset_strobes got ls=%b fs=%b frame=%0d want 0 0 0", ls_b, fs_b, frame_b);
    else n_pass++;
    n_chk++;
    if (act_vec(1) !== rst_vec) $display("FAIL reset_small got %h want %h", act_vec(1), rst_vec);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (act_vec(0) !== rst_vec) $display("FAIL reset_hold_no_ena got %h want %h", act_vec(0), rst_vec);
    else n_pass++;
  endtask

  task automatic test_hsync();
    int fall_at = -1, rise_at = -1, de_off_at = -1;
    logic hs_prev, de_prev;
    ena_b = 1'b1;
    tick();
    n_chk++;
    if (hpos_b !== 10'd1 || disp_b !== 1'b1) $display("FAIL first_edge got hpos=%0d de=%b want 1 1", hpos_b, disp_b);
    else n_pass++;
    hs_prev = hsync_b; de_prev = disp_b;
    for (int k = 0; k < 900 && hpos_b != 10'd760; k++) begin
      tick();
      if (hs_prev && !hsync_b && fall_at < 0) fall_at = int'(hpos_b);
      if (!hs_prev && hsync_b && rise_at < 0) rise_at = int'(hpos_b);
      if (de_prev && !disp_b && de_off_at < 0) de_off_at = int'(hpos_b);
      hs_prev = hsync_b; de_prev = disp_b;
    end
    n_chk++;
    if (fall_at != 656) $display("FAIL hsync_fall got hpos=%0d want 656", fall_at);
    else n_pass++;
    n_chk++;
    if (rise_at != 752) $display("FAIL hsync_rise got hpos=%0d want 752", rise_at);
    else n_pass++;
    n_chk++;
    if (de_off_at != 640) $display("FAIL display_off got hpos=%0d want 640", de_off_at);
    else n_pass++;
  endtask

  task automatic test_line_wrap();
    for (int k = 0; k < 1000 && hpos_b != 10'd799; k++) tick();
    n_chk++;
    if (hpos_b !== 10'd799 || vpos_b !== 10'd0) $display("FAIL reach_799 got (%0d,%0d) want (799,0)", hpos_b, vpos_b);
    else n_pass++;
    tick();
    n_chk++;
    if ({hpos_b, vpos_b, ls_b, fs_b} !== {10'd0, 10'd1, 1'b1, 1'b0})
      $display("FAIL line_wrap got hpos=%0d vpos=%0d ls=%b fs=%b want 0 1 1 0", hpos_b, vpos_b, ls_b, fs_b);
    else n_pass++;
    tick();
    n_chk++;
    if (ls_b !== 1'b0 || hpos_b !== 10'd1) $display("FAIL line_strobe_width got ls=%b hpos=%0d want 0 1", ls_b, hpos_b);
    else n_pass++;
  endtask

  task automatic test_ena_hold();
    for (int k = 0; k < 1000 && hpos_b != 10'd100; k++) tick();
    ena_b = 1'b0;
    repeat (5) begin
      tick();
      n_chk++;
      if (hpos_b !== 10'd100 || ls_b !== 1'b0 || fs_b !== 1'b0)
        $display("FAIL hold_100 got hpos=%0d ls=%b fs=%b want 100 0 0", hpos_b, ls_b, fs_b);
      else n_pass++;
    end
    ena_b = 1'b1;
    tick();
    n_chk++;
    if (hpos_b !== 10'd101) $display("FAIL resume_101 got %0d want 101", hpos_b);
    else n_pass++;
    for (int k = 0; k < 1000 && hpos_b != 10'd799; k++) tick();
    ena_b = 1'b0;
    repeat (3) begin
      tick();
      n_chk++;
      if (hpos_b !== 10'd799 || ls_b !== 1'b0) $display("FAIL hold_799 got hpos=%0d ls=%b want 799 0", hpos_b, ls_b);
      else n_pass++;
    end
    ena_b = 1'b1;
    tick();
    n_chk++;
    if ({hpos_b, vpos_b, ls_b} !== {10'd0, 10'd2, 1'b1})
      $display("FAIL wrap_after_hold got hpos=%0d vpos=%0d ls=%b want 0 2 1", hpos_b, vpos_b, ls_b);
    else n_pass++;
  endtask

  task automatic test_frame_wrap();
    logic [7:0] exp_fr;
    ena_s = 1'b1;
    for (int k = 0; k < 600 && !(hpos_s == 10'd28 && vpos_s == 10'd16); k++) begin
      tick();
      n_chk++;
      if (vsync_s !== ((vpos_s == 10'd12 || vpos_s == 10'd13) ? 1'b0 : 1'b1))
        $display("FAIL vsync_line got vs=%b at vpos=%0d", vsync_s, vpos_s);
      else n_pass++;
    end
    tick();
`ifdef VGA_TIMING_FRAME_CNT_EN
    exp_fr = 8'd1;
`else
    exp_fr = 8'd0;
`endif
    n_chk++;
    if ({hpos_s, vpos_s, fs_s, ls_s, frame_s} !== {10'd0, 10'd0, 1'b1, 1'b1, exp_fr})
      $display("FAIL frame_wrap got (%0d,%0d) fs=%b ls=%b frame=%0d want (0,0) 1 1 %0d", hpos_s, vpos_s, fs_s, ls_s, frame_s, exp_fr);
    else n_pass++;
    tick();
    n_chk++;
    if (fs_s !== 1'b0 || frame_s !== exp_fr) $display("FAIL frame_strobe_width got fs=%b frame=%0d want 0 %0d", fs_s, frame_s, exp_fr);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      ena_b = ($urandom_range(0, 3) != 0);
      ena_s = ($urandom_range(0, 3) != 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (act_vec(i) !== exp_vec(i)) $display("FAIL random_%0d cycle %0d got %h want %h", i, k, act_vec(i), exp_vec(i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [32:0] rst_vec;
    rst_vec = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    ena_b = 1'b1; ena_s = 1'b1;
    for (int k = 0; k < 600 && !(m_vp[1] == 5 && m_hp[1] == 10); k++) tick();
    n_chk++;
    if (act_vec(1) !== exp_vec(1)) $display("FAIL pre_reset_pos got %h want %h", act_vec(1), exp_vec(1));
    else n_pass++;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (act_vec(i) !== rst_vec) $display("FAIL async_reset_%0d got %h want %h", i, act_vec(i), rst_vec);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (hpos_b !== 10'd1 || hpos_s !== 10'd1) $display("FAIL post_reset_resume got %0d %0d want 1 1", hpos_b, hpos_s);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_line_wrap();
    test_ena_hold();
    test_frame_wrap();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
